// File: rtl/pc_sequencer_if.sv
// Harness/decoder <-> program-counter sequencer bundle: control requests in,
// fetch address and status out.
interface pc_sequencer_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic            branch_op;
    logic            halt_op;
    logic [PC_W-1:0] branch_tgt;
    logic            jump_flag;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            done;

    modport master (
        output start, branch_op, halt_op, branch_tgt, jump_flag,
        input  pc, fetch_valid, done
    );

    modport slave (
        input  start, branch_op, halt_op, branch_tgt, jump_flag,
        output pc, fetch_valid, done
    );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: steps the PC, issues fetches, resolves BLQZ branches, runs start/halt handshake.
// Latency: pc/done registered, one-cycle update; every branch costs exactly one bubble cycle.
// Backpressure: none; fetch_valid drops for the branch bubble and outside RUN.
module pc_sequencer #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input logic          clock,
    input logic          reset_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        BR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic            done_q, done_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            tgt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pc_d    = START_PC;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Halt outranks a simultaneous branch; the branch is simply dropped.
                if (bus.halt_op) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (bus.branch_op) begin
                    tgt_d   = bus.branch_tgt;
                    state_d = BR_WAIT;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            BR_WAIT: begin
                // The ALU's registered flag for this BLQZ is valid only in this bubble.
                pc_d    = bus.jump_flag ? tgt_q : pc_q + 1'b1;
                state_d = RUN;
            end
            DONE: begin
                // Harness must drop start before a new run can be accepted.
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.done        = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential stepping and wrap, taken/not-taken
// branches, halt priority with start handshake, and branch-to-self loops.
module tb_pc_sequencer;

    logic clock;
    logic reset_n;

    int n_checks;
    int n_fail;

    pc_sequencer_if #(.PC_W(10)) ifa ();
    pc_sequencer_if #(.PC_W(10)) ifb ();

    pc_sequencer #(.PC_W(10), .START_PC(10'd0)) u_dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    pc_sequencer #(.PC_W(10), .START_PC(10'd1022)) u_dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    assign ifb.start      = ifa.start;
    assign ifb.branch_op  = ifa.branch_op;
    assign ifb.halt_op    = ifa.halt_op;
    assign ifb.branch_tgt = ifa.branch_tgt;
    assign ifb.jump_flag  = ifa.jump_flag;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_a(input string tag, input int exp_pc, input int exp_fv,
                           input int exp_done);
        check({tag, ".pc"},   int'(ifa.pc),          exp_pc);
        check({tag, ".fv"},   int'(ifa.fetch_valid), exp_fv);
        check({tag, ".done"}, int'(ifa.done),        exp_done);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    // From IDLE: accept start, then step sequentially n times.
    task automatic run_to(input int n);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n        = 1'b0;
        ifa.start      = 1'b0;
        ifa.branch_op  = 1'b0;
        ifa.halt_op    = 1'b0;
        ifa.branch_tgt = '0;
        ifa.jump_flag  = 1'b0;
        repeat (2) tick();
        check_a("reset", 0, 0, 0);
        reset_n = 1'b1;
        tick();
        check_a("idle", 0, 0, 0);

        // Sequential stepping, plus wrap on the START_PC=1022 instance
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_a($sformatf("seq%0d", i), i, 1, 0);
            check($sformatf("wrap%0d.pc", i), int'(ifb.pc), (1022 + i) % 1024);
            tick();
        end
        tick();
        check_a("seq5", 5, 1, 0);

        // Asynchronous reset mid-RUN, with start held high
        ifa.start = 1'b1;
        reset_n   = 1'b0;
        #1;
        check_a("async_rst", 0, 0, 0);
        ifa.start = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_a("post_rst", 0, 0, 0);

        // Taken branch at 0x10 -> 0x03
        do_reset();
        run_to(16);
        check_a("tk_pre", 16, 1, 0);
        ifa.branch_op  = 1'b1;
        ifa.branch_tgt = 10'h003;
        tick();
        check_a("tk_bubble", 16, 0, 0);
        ifa.branch_op = 1'b0;
        ifa.jump_flag = 1'b1;
        tick();
        ifa.jump_flag = 1'b0;
        check_a("tk_tgt", 3, 1, 0);

        // Not-taken branch, then stray jump_flag in RUN
        do_reset();
        run_to(16);
        ifa.branch_op = 1'b1;
        tick();
        check_a("nt_bubble", 16, 0, 0);
        ifa.branch_op = 1'b0;
        tick();
        check_a("nt_next", 17, 1, 0);
        ifa.jump_flag = 1'b1;
        tick();
        ifa.jump_flag = 1'b0;
        check_a("stray_jf", 18, 1, 0);

        // Halt wins over branch; start handshake
        do_reset();
        run_to(32);
        ifa.halt_op    = 1'b1;
        ifa.branch_op  = 1'b1;
        ifa.branch_tgt = 10'h003;
        tick();
        ifa.halt_op   = 1'b0;
        ifa.branch_op = 1'b0;
        check_a("halt", 32, 0, 1);
        ifa.start = 1'b1;
        repeat (2) tick();
        check_a("halt_hold", 32, 0, 1);
        ifa.start = 1'b0;
        tick();
        check_a("halt_idle", 32, 0, 1);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        check_a("restart", 0, 1, 0);

        // Branch to own address, three taken iterations then fall through
        do_reset();
        run_to(8);
        ifa.branch_tgt = 10'h008;
        for (int i = 0; i < 3; i++) begin
            ifa.branch_op = 1'b1;
            tick();
            check_a($sformatf("loop%0d_bub", i), 8, 0, 0);
            ifa.branch_op = 1'b0;
            ifa.jump_flag = 1'b1;
            tick();
            ifa.jump_flag = 1'b0;
            check_a($sformatf("loop%0d_pc", i), 8, 1, 0);
        end
        ifa.branch_op = 1'b1;
        tick();
        ifa.branch_op = 1'b0;
        tick();
        check_a("loop_exit", 9, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
